pyc_fifo_level: RTL and testbench
=================================

PYC_FIFO_LEVEL -- requirements
Module: pyc_fifo_level

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, the storage entries (>=1; a non-positive value SHALL stop simulation with an error message).
REQ-003 The block SHALL have parameter AFULL_LVL, default DEPTH-1, the almost-full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 1, the almost-empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous discard of all contents.
- in_valid  in  1  producer offers data.
- in_ready  out  1  FIFO accepts data.
- in_data  in  WIDTH  producer data.
- out_valid  out  1  FIFO offers data.
- out_ready  in  1  consumer accepts data.
- out_data  out  WIDTH  head data.
- count  out  CNT_W  stored entries, with CNT_W = clog2(DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.

Function
REQ-006 The block SHALL define push = in_valid && in_ready and pop = out_valid && out_ready, both sampled at the rising edge of clk.
REQ-007 The block SHALL drive in_ready = !flush && (count < DEPTH || pop), so a full FIFO accepts data in a cycle in which it pops.
REQ-008 The block SHALL drive out_valid = !flush && count != 0, and out_data SHALL equal the head entry whenever out_valid is 1 (bypass exception: REQ-020).
REQ-009 The block SHALL deliver data in strict FIFO order; minimum latency from push to out_valid SHALL be 1 cycle.
REQ-010 On push only, the block SHALL write in_data at wr_ptr, advance wr_ptr and increment count.
REQ-011 On pop only, the block SHALL advance rd_ptr and decrement count.
REQ-012 On push and pop together, the block SHALL write and advance both pointers, and count SHALL be unchanged.
REQ-013 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-power-of-2 values; for DEPTH=1 they SHALL stay 0.
REQ-014 count, full, empty, almost_full and almost_empty SHALL be decoded from registered state only, with no combinational path from any input.
REQ-015 When flush=1 at a clock edge, the block SHALL reset rd_ptr, wr_ptr and count to 0 at that edge and SHALL neither push nor pop in that cycle; storage contents SHALL be don't-care.
REQ-016 count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-017 When rst_n=0 at a rising edge, the block SHALL clear rd_ptr, wr_ptr and count to 0; reset SHALL take priority over flush, push and pop.
REQ-018 After reset, the outputs SHALL be: out_valid=0, in_ready=1, count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_LVL==0); out_data SHALL be don't-care.
REQ-019 Reset asserted mid-operation SHALL discard all stored entries, and no pre-reset data SHALL appear after release.

Configuration
REQ-020 When macro PYC_FIFO_BYPASS_EN is defined, and count==0 and flush=0, the block SHALL drive out_valid=in_valid and out_data=in_data combinationally; a beat consumed in that cycle SHALL NOT be written and count SHALL stay 0; a beat not consumed SHALL be stored normally.
REQ-021 When PYC_FIFO_BYPASS_EN is undefined, the block SHALL have no combinational path from in_* to out_*, and minimum latency SHALL be 1 cycle.

Verification (WIDTH=8, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-022 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1,2,3,4; almost_full=1 at count 3; full=1 and in_ready=0 at count 4.
REQ-023 From full, set out_ready=1 and in_valid=1 with 0x55 -> simultaneous push/pop, count stays 4, output sequence 0x11,0x22,0x33,0x44,0x55.
REQ-024 Run 10 push/pop cycles at count 1 -> pointers wrap, data order preserved, almost_empty=1 throughout.
REQ-025 Hold 3 entries and assert flush for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 during flush; count=0 and empty=1 next cycle; flushed data never emitted.
REQ-026 Drive rst_n=0 for 1 cycle with 2 entries stored -> outputs match REQ-018 on the next cycle; a following push of 0xA5 is output as the first beat.
REQ-027 Empty FIFO with in_valid=1, 0x77, out_ready=1 -> with PYC_FIFO_BYPASS_EN, out_valid=1 and out_data=0x77 in the same cycle and count stays 0; without it, out_valid=1 one cycle later.

Source files
------------

// File: rtl/pyc_fifo_level.sv
// Synchronous FIFO with valid/ready handshake, flush and level flags.
// Optional same-cycle bypass on an empty FIFO when PYC_FIFO_BYPASS_EN is defined.
module pyc_fifo_level #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "pyc_fifo_level: DEPTH must be >= 1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  assign w_empty = (r_count == CNT_W'(0));

`ifdef PYC_FIFO_BYPASS_EN
  assign w_byp = w_empty && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // Handshake and head presentation; bypass forwards the producer beat directly.
  always_comb begin
    out_valid = 1'b0;
    out_data  = r_mem[r_rd_ptr];
    if (w_byp) begin
      out_valid = in_valid;
      out_data  = in_data;
    end else begin
      out_valid = !flush && !w_empty;
    end
  end

  assign w_pop    = out_valid && out_ready;
  assign in_ready = !flush && ((r_count < CNT_W'(DEPTH)) || w_pop);
  assign w_push   = in_valid && in_ready;

  // A bypassed beat that is consumed never touches storage.
  assign w_wr_en = w_push && !(w_byp && w_pop);
  assign w_rd_en = w_pop && !w_byp;

  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_rd_ptr + PTR_W'(1);

  // Pointer and occupancy state; reset outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else if (flush) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_wr_en) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_en) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_en) r_mem[r_wr_ptr] <= in_data;
  end

  // Level flags decode only registered occupancy.
  assign count        = r_count;
  assign full         = (r_count == CNT_W'(DEPTH));
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AFULL_LVL));
  assign almost_empty = (r_count <= CNT_W'(AEMPTY_LVL));

endmodule

// File: tb/tb_pyc_fifo_level.sv
// Randomized and directed bench for pyc_fifo_level against a queue-based reference model.
module tb_pyc_fifo_level;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];

  pyc_fifo_level #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, compare every output against the model, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [7:0] din, input logic ordy);
    int n;
    logic byp, eov, eir, epush, epop;
    logic [7:0] edata;
    @(negedge clk);
    rst_n = rst; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    n   = q.size();
    byp = 1'b0;
`ifdef PYC_FIFO_BYPASS_EN
    byp = (n == 0) && !fl;
`endif
    eov   = byp ? iv : (!fl && n != 0);
    edata = byp ? din : ((n != 0) ? q[0] : 8'h00);
    epop  = eov && ordy;
    eir   = !fl && (n < DEPTH || epop);
    epush = iv && eir;
    check_eq("in_ready", 32'(in_ready), 32'(eir));
    check_eq("out_valid", 32'(out_valid), 32'(eov));
    if (eov) check_eq("out_data", 32'(out_data), 32'(edata));
    check_eq("count", 32'(count), 32'(n));
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("almost_full", 32'(almost_full), 32'(n >= 3));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= 1));
    if (!rst || fl) begin
      q.delete();
    end else begin
      if (epop) got.push_back(edata);
      if (!(byp && epop)) begin
        if (epop) void'(q.pop_front());
        if (epush) q.push_back(din);
      end
    end
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h44; exp_seq[4] = 8'h55;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_empty", 32'(empty), 32'd1);

    // Fill to full, then simultaneous push/pop at full, then drain
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    check_eq("pushpop_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("order_len", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'h00;
      check_eq("order_data", 32'(g), 32'(exp_seq[i]));
    end

    // Steady-state at one entry: pointers wrap repeatedly
    step(1'b1, 1'b0, 1'b1, 8'h60, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h61 + i), 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Flush with three entries held and a producer offering data
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-operation reset discards stored data
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    got.delete();
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("post_rst_first", 32'((got.size() > 0) ? got[0] : 8'h00), 32'h0000_00A5);

    // Empty FIFO with a beat offered and consumer ready
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5));
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
